muldiv_hilo_ctrl: RTL

Sequencer and owner of the HI/LO register pair for the multi-cycle Mult and Div units.
- Accepts decoded R-type funct from the execute stage and issues one-cycle start pulses to Mult/Div.
- Captures their results into HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Generates the pipeline stall: MULT/DIV are non-blocking; only a HI/LO access or a new mult/div while busy stalls.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/hilo_regs.sv | 35 +++
 rtl/muldiv_hilo_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM state type for the mult/div HI/LO controller.
package muldiv_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_state_t;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair with independent write enables and
// asynchronous active-low clear.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // HI/LO storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else begin
      if (hi_we) hi_r <= hi_d;
      else       hi_r <= hi_r;
      if (lo_we) lo_r <= lo_d;
      else       lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the multi-cycle Mult/Div units and owner of HI/LO.
// Optional macro HILO_FWD_EN: forward the unit result to a waiting MFHI/MFLO in the done cycle.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LAT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic             mul_start,
  output logic             div_start,
  output logic             md_sign,
  input  logic             mul_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MAX - 1);

  md_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             mul_start_r, div_start_r, md_sign_r, timeout_r;
  logic             is_mul_s, is_div_s, is_md_s, is_mf_s, is_mt_s;
  logic             busy_s, done_s, mf_hold_s, go_s, dz_s, start_s;
  logic             hi_we_s, lo_we_s;
  logic [WIDTH-1:0] hi_d_s, lo_d_s, hi_q_s, lo_q_s, hi_src_s, lo_src_s, mf_data_s;

  assign is_mul_s = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div_s = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_md_s  = is_mul_s || is_div_s;
  assign is_mf_s  = (funct == F_MFHI) || (funct == F_MFLO);
  assign is_mt_s  = (funct == F_MTHI) || (funct == F_MTLO);

  assign busy_s = (state_r != IDLE);
  assign done_s = ((state_r == MUL_BUSY) && mul_done) || ((state_r == DIV_BUSY) && div_done);

`ifdef HILO_FWD_EN
  assign mf_hold_s = 1'b0;
`else
  // Without forwarding a waiting MF read only sees the result once it is in HI/LO.
  assign mf_hold_s = is_mf_s;
`endif

  assign stall   = op_valid && (is_md_s || is_mf_s || is_mt_s) && busy_s && (!done_s || mf_hold_s);
  assign go_s    = op_valid && !stall;
  assign dz_s    = go_s && is_div_s && (srcb == {WIDTH{1'b0}});
  assign start_s = go_s && is_md_s && !dz_s;

  // FSM, start pulses, operand signedness and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mul_start_r <= 1'b0;
      div_start_r <= 1'b0;
      md_sign_r   <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      mul_start_r <= start_s && is_mul_s;
      div_start_r <= start_s && is_div_s;
      if (start_s) begin
        state_r   <= is_mul_s ? MUL_BUSY : DIV_BUSY;
        md_sign_r <= ~funct[0];
        cnt_r     <= {CNT_W{1'b0}};
      end else if (busy_s) begin
        if (done_s) begin
          state_r <= IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_r   <= IDLE;
          timeout_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        state_r <= IDLE;
      end
    end
  end

  // HI/LO write selection; a retiring MT/divide-by-zero is younger than the
  // finishing operation, so its write wins on the register it touches.
  always_comb begin
    hi_we_s = 1'b0;
    lo_we_s = 1'b0;
    hi_d_s  = (state_r == MUL_BUSY) ? mul_hi : div_hi;
    lo_d_s  = (state_r == MUL_BUSY) ? mul_lo : div_lo;
    if (done_s) begin
      hi_we_s = 1'b1;
      lo_we_s = 1'b1;
    end else begin
      hi_we_s = 1'b0;
      lo_we_s = 1'b0;
    end
    if (dz_s) begin
      hi_we_s = 1'b1;
      lo_we_s = 1'b1;
      hi_d_s  = srca;
      lo_d_s  = {WIDTH{1'b1}};
    end else if (go_s && (funct == F_MTHI)) begin
      hi_we_s = 1'b1;
      hi_d_s  = srca;
    end else if (go_s && (funct == F_MTLO)) begin
      lo_we_s = 1'b1;
      lo_d_s  = srca;
    end else begin
      hi_we_s = hi_we_s;
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .hi_we (hi_we_s),
    .lo_we (lo_we_s),
    .hi_d  (hi_d_s),
    .lo_d  (lo_d_s),
    .hi    (hi_q_s),
    .lo    (lo_q_s)
  );

  // MFHI/MFLO read data
  always_comb begin
    hi_src_s  = hi_q_s;
    lo_src_s  = lo_q_s;
    mf_data_s = {WIDTH{1'b0}};
`ifdef HILO_FWD_EN
    if (done_s) begin
      hi_src_s = (state_r == MUL_BUSY) ? mul_hi : div_hi;
      lo_src_s = (state_r == MUL_BUSY) ? mul_lo : div_lo;
    end else begin
      hi_src_s = hi_q_s;
      lo_src_s = lo_q_s;
    end
`endif
    if (op_valid && is_mf_s) begin
      mf_data_s = (funct == F_MFHI) ? hi_src_s : lo_src_s;
    end else begin
      mf_data_s = {WIDTH{1'b0}};
    end
  end

  assign mf_data   = mf_data_s;
  assign mul_start = mul_start_r;
  assign div_start = div_start_r;
  assign md_sign   = md_sign_r;
  assign busy      = busy_s;
  assign timeout   = timeout_r;

endmodule
